// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter: shares one synchronous ROM among NUM_REQ requesters.
// Grants at most one address per clock (round-robin) and tags each returned
// byte back to the requester that asked for it.
//
// Optional feature macro: ROM_ARB_FIXED_PRIO0_EN
//   defined   -> requester 0 has absolute priority; requesters 1..NUM_REQ-1
//                share the remaining slots round-robin (ptr is not advanced
//                by grants to requester 0).
//   undefined -> plain round-robin over all requesters.
//
// Handshake: a requester holds req[i] and its address slot stable until
// ack[i]; the read is taken on the posedge where req[i] & ack[i]. Keeping
// req high gives back-to-back reads. The return path has no backpressure:
// rd_valid[i] is a single-cycle pulse carrying rd_data, in grant order,
// ROM_LATENCY clocks after the ack edge.
module rom_read_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int ROM_LATENCY = 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic [DATA_W-1:0]         rom_q
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Round-robin search start; reset to 0.
  logic [PTR_W-1:0]   ptr;
  // Address presented while idle so the ROM input does not toggle.
  logic [ADDR_W-1:0]  last_addr;

  logic [NUM_REQ-1:0] rr_req;
  logic               found;
  logic               rr_gnt;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   cand;
  logic               grant;
  logic [ADDR_W-1:0]  gnt_addr;

  // Return-path tag pipeline: one valid bit and one one-hot tag per stage.
  logic [ROM_LATENCY-1:0] vld_pipe;
  logic [NUM_REQ-1:0]     tag_pipe [ROM_LATENCY];

  // Pick the winner: optional fixed priority for 0, then first requester at or after ptr.
  always_comb begin
    rr_req  = req;
    found   = 1'b0;
    rr_gnt  = 1'b0;
    gnt_idx = '0;
    cand    = '0;
`ifdef ROM_ARB_FIXED_PRIO0_EN
    rr_req[0] = 1'b0;
    if (req[0]) begin
      found = 1'b1;
    end
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && rr_req[cand]) begin
        found   = 1'b1;
        rr_gnt  = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign grant       = found & reset_n;
  assign ack         = grant ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign gnt_addr    = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign rom_address = grant ? gnt_addr : last_addr;

  // Advance the round-robin pointer past a round-robin winner; remember its address.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ptr       <= '0;
      last_addr <= '0;
    end else if (grant) begin
      last_addr <= gnt_addr;
      if (rr_gnt) begin
        ptr <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  // Shift the grant tag alongside the ROM's internal latency; reset drops in-flight reads.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int s = 0; s < ROM_LATENCY; s++) begin
        vld_pipe[s] <= 1'b0;
        tag_pipe[s] <= '0;
      end
    end else begin
      vld_pipe[0] <= grant;
      tag_pipe[0] <= ack;
      for (int s = 1; s < ROM_LATENCY; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        tag_pipe[s] <= tag_pipe[s-1];
      end
    end
  end

  assign rd_valid = vld_pipe[ROM_LATENCY-1] ? tag_pipe[ROM_LATENCY-1] : '0;
  assign rd_data  = vld_pipe[ROM_LATENCY-1] ? rom_q : '0;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench for rom_read_arbiter: directed vector table followed by random
// traffic checked against a behavioural model and a return queue.
module tb_rom_read_arbiter;

  localparam int N   = 4;
  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int LAT = 1;
  localparam int EW  = N + DW;
`ifdef ROM_ARB_FIXED_PRIO0_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]  ack;
  logic [N-1:0]  rd_valid;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] rom_address;
  logic [DW-1:0] rom_q;

  // ---------------- clock / ROM ----------------
  always #5 clock = ~clock;

  logic [DW-1:0] rom_pipe [LAT];
  always @(posedge clock) begin
    rom_pipe[0] <= rom_address[7:0] ^ 8'hA5;
    for (int s = 1; s < LAT; s++) rom_pipe[s] <= rom_pipe[s-1];
  end
  assign rom_q = rom_pipe[LAT-1];

  rom_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(LAT)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_addr(req_addr),
    .ack(ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .rom_address(rom_address), .rom_q(rom_q)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit            rst;
    logic [N-1:0]  req;
    logic [N*AW-1:0] addr;
    logic [N-1:0]  ack;
    logic [AW-1:0] rom_a;
    logic [N-1:0]  rv;
    logic [DW-1:0] rd;
    bit            chk;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [N*AW-1:0] a4(logic [15:0] a3, logic [15:0] a2,
                                         logic [15:0] a1, logic [15:0] a0);
    return {a3, a2, a1, a0};
  endfunction

  function automatic void add(bit rst, logic [N-1:0] rq, logic [N*AW-1:0] ad,
                              logic [N-1:0] ak, logic [AW-1:0] ra,
                              logic [N-1:0] rv, logic [DW-1:0] rd, bit chk);
    vec_t v;
    v.rst = rst; v.req = rq; v.addr = ad; v.ack = ak;
    v.rom_a = ra; v.rv = rv; v.rd = rd; v.chk = chk;
    tbl.push_back(v);
  endfunction

  task automatic apply_row(int i, vec_t v);
    reset_n  = ~v.rst;
    req      = v.req;
    req_addr = v.addr;
    #1;
    check($sformatf("row%0d ack", i), 32'(ack), 32'(v.ack));
    if (v.chk) begin
      check($sformatf("row%0d rom_address", i), 32'(rom_address), 32'(v.rom_a));
      check($sformatf("row%0d rd_valid", i), 32'(rd_valid), 32'(v.rv));
      check($sformatf("row%0d rd_data", i), 32'(rd_data), 32'(v.rd));
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  // ---------------- reference model ----------------
  int m_ptr = 0;
  logic [AW-1:0] m_last = '0;
  logic [EW-1:0] exp_q[$];

  task automatic rand_step(int cyc, bit rst, logic [N-1:0] rq,
                           logic [N*AW-1:0] ad, bit chk_a);
    int g;
    int best;
    logic [N-1:0]  e_ack;
    logic [AW-1:0] e_addr;
    logic [EW-1:0] e_ret;
    reset_n  = ~rst;
    req      = rq;
    req_addr = ad;
    #1;
    g = -1;
    if (!rst) begin
      if (FIXED && rq[0]) g = 0;
      else begin
        best = N;
        for (int i = 0; i < N; i++) begin
          if (rq[i] && !(FIXED && i == 0) && ((i - m_ptr + N) % N) < best) begin
            best = (i - m_ptr + N) % N;
            g = i;
          end
        end
      end
    end
    e_ack  = (g >= 0) ? (N'(1) << g) : '0;
    e_addr = (g >= 0) ? ad[g*AW +: AW] : m_last;
    check($sformatf("rnd%0d ack", cyc), 32'(ack), 32'(e_ack));
    if (chk_a) check($sformatf("rnd%0d rom_address", cyc), 32'(rom_address), 32'(e_addr));
    e_ret = exp_q.pop_front();
    check($sformatf("rnd%0d return", cyc), 32'({rd_valid, rd_data}), 32'(e_ret));
    if (rst) begin
      exp_q.delete();
      for (int s = 0; s < LAT; s++) exp_q.push_back('0);
      m_ptr  = 0;
      m_last = '0;
    end else begin
      exp_q.push_back((g >= 0) ? {e_ack, e_addr[7:0] ^ 8'hA5} : '0);
      if (g >= 0) begin
        m_last = e_addr;
        if (!(FIXED && g == 0)) m_ptr = (g + 1) % N;
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [N*AW-1:0] a;
    add(1, 4'b0000, '0, 4'b0000, 16'h0000, 4'b0000, 8'h00, 0);
    add(1, 4'b0000, '0, 4'b0000, 16'h0000, 4'b0000, 8'h00, 1);
`ifdef ROM_ARB_FIXED_PRIO0_EN
    // requester 0 dominates, then 1 and 3 alternate
    a = a4(16'h3303, 16'h0000, 16'h3101, 16'h3000);
    add(0, 4'b1011, a, 4'b0001, 16'h3000, 4'b0000, 8'h00, 1);
    add(0, 4'b1011, a, 4'b0001, 16'h3000, 4'b0001, 8'hA5, 1);
    add(0, 4'b1011, a, 4'b0001, 16'h3000, 4'b0001, 8'hA5, 1);
    add(0, 4'b1011, a, 4'b0001, 16'h3000, 4'b0001, 8'hA5, 1);
    add(0, 4'b1010, a, 4'b0010, 16'h3101, 4'b0001, 8'hA5, 1);
    add(0, 4'b1010, a, 4'b1000, 16'h3303, 4'b0010, 8'hA4, 1);
    add(0, 4'b1010, a, 4'b0010, 16'h3101, 4'b1000, 8'hA6, 1);
    add(0, 4'b1010, a, 4'b1000, 16'h3303, 4'b0010, 8'hA4, 1);
    add(0, 4'b0000, a, 4'b0000, 16'h3303, 4'b1000, 8'hA6, 1);
`else
    // single read from requester 2, then idle and reset
    a = a4(16'h0000, 16'h0010, 16'h0000, 16'h0000);
    add(0, 4'b0100, a, 4'b0100, 16'h0010, 4'b0000, 8'h00, 1);
    add(0, 4'b0000, a, 4'b0000, 16'h0010, 4'b0100, 8'hB5, 1);
    add(0, 4'b0000, a, 4'b0000, 16'h0010, 4'b0000, 8'h00, 1);
    add(1, 4'b0000, a, 4'b0000, 16'h0010, 4'b0000, 8'h00, 1);
    add(1, 4'b0000, a, 4'b0000, 16'h0000, 4'b0000, 8'h00, 1);
    // all four requesting: 0,1,2,3,0,1,2,3
    a = a4(16'h1303, 16'h1202, 16'h1101, 16'h1000);
    add(0, 4'b1111, a, 4'b0001, 16'h1000, 4'b0000, 8'h00, 1);
    add(0, 4'b1111, a, 4'b0010, 16'h1101, 4'b0001, 8'hA5, 1);
    add(0, 4'b1111, a, 4'b0100, 16'h1202, 4'b0010, 8'hA4, 1);
    add(0, 4'b1111, a, 4'b1000, 16'h1303, 4'b0100, 8'hA7, 1);
    add(0, 4'b1111, a, 4'b0001, 16'h1000, 4'b1000, 8'hA6, 1);
    add(0, 4'b1111, a, 4'b0010, 16'h1101, 4'b0001, 8'hA5, 1);
    add(0, 4'b1111, a, 4'b0100, 16'h1202, 4'b0010, 8'hA4, 1);
    add(0, 4'b1111, a, 4'b1000, 16'h1303, 4'b0100, 8'hA7, 1);
    add(0, 4'b0000, a, 4'b0000, 16'h1303, 4'b1000, 8'hA6, 1);
    // 0 and 1 alternate, then 1 drops out
    a = a4(16'h0000, 16'h0000, 16'h2121, 16'h2010);
    add(0, 4'b0011, a, 4'b0001, 16'h2010, 4'b0000, 8'h00, 1);
    add(0, 4'b0011, a, 4'b0010, 16'h2121, 4'b0001, 8'hB5, 1);
    add(0, 4'b0011, a, 4'b0001, 16'h2010, 4'b0010, 8'h84, 1);
    add(0, 4'b0011, a, 4'b0010, 16'h2121, 4'b0001, 8'hB5, 1);
    add(0, 4'b0001, a, 4'b0001, 16'h2010, 4'b0010, 8'h84, 1);
    add(0, 4'b0001, a, 4'b0001, 16'h2010, 4'b0001, 8'hB5, 1);
    add(0, 4'b0000, a, 4'b0000, 16'h2010, 4'b0001, 8'hB5, 1);
    // requester 3 streaming consecutive addresses
    add(0, 4'b1000, a4(16'h0100, 0, 0, 0), 4'b1000, 16'h0100, 4'b0000, 8'h00, 1);
    add(0, 4'b1000, a4(16'h0101, 0, 0, 0), 4'b1000, 16'h0101, 4'b1000, 8'hA5, 1);
    add(0, 4'b1000, a4(16'h0102, 0, 0, 0), 4'b1000, 16'h0102, 4'b1000, 8'hA4, 1);
    add(0, 4'b1000, a4(16'h0103, 0, 0, 0), 4'b1000, 16'h0103, 4'b1000, 8'hA7, 1);
    add(0, 4'b0000, a4(16'h0103, 0, 0, 0), 4'b0000, 16'h0103, 4'b1000, 8'hA6, 1);
    // reset right after a grant; pointer restarts at 0
    a = a4(16'h0000, 16'h0030, 16'h0000, 16'h0000);
    add(0, 4'b0100, a, 4'b0100, 16'h0030, 4'b0000, 8'h00, 1);
    add(1, 4'b0100, a, 4'b0000, 16'h0030, 4'b0100, 8'h95, 1);
    a = a4(16'h0350, 16'h0040, 16'h0000, 16'h0000);
    add(0, 4'b1100, a, 4'b0100, 16'h0040, 4'b0000, 8'h00, 1);
    add(0, 4'b1100, a, 4'b1000, 16'h0350, 4'b0100, 8'hE5, 1);
    add(0, 4'b0000, a, 4'b0000, 16'h0350, 4'b1000, 8'hF5, 1);
    add(0, 4'b0000, a, 4'b0000, 16'h0350, 4'b0000, 8'h00, 1);
`endif
    foreach (tbl[i]) apply_row(i, tbl[i]);

    // random traffic against the model, starting from a reset
    for (int s = 0; s < LAT; s++) exp_q.push_back('0);
    rand_step(0, 1'b1, '0, '0, 1'b0);
    rand_step(1, 1'b1, '0, '0, 1'b1);
    for (int c = 2; c < 400; c++) begin
      logic [N-1:0] rq;
      rq = ($urandom_range(0, 3) == 0) ? 4'b1111 : N'($urandom_range(0, 15));
      rand_step(c, ($urandom_range(0, 39) == 0), rq, {$urandom, $urandom}, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
